shift_reg_arbiter: RTL and testbench

SHIFT_REG_ARBITER -- requirements
Module: shift_reg_arbiter

---
 rtl/shift_reg_arbiter_if.sv | 26 ++
 rtl/shift_reg_arbiter.sv | 89 ++++++++
 tb/tb_shift_reg_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_arbiter_if.sv
// Bus between two parallel-load requesters and the shared serialising shift register.
// The arbiter uses the slave view; whatever drives the requests uses the master view.
interface shift_reg_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             i_req0;
    logic [WIDTH-1:0] i_data0;
    logic             i_req1;
    logic [WIDTH-1:0] i_data1;
    logic             o_gnt0;
    logic             o_gnt1;
    logic [WIDTH-1:0] o_storedValue;
    logic             o_serial;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_req0, i_data0, i_req1, i_data1,
        input  o_gnt0, o_gnt1, o_storedValue, o_serial, o_busy, o_done
    );

    modport slave (
        input  i_req0, i_data0, i_req1, i_data1,
        output o_gnt0, o_gnt1, o_storedValue, o_serial, o_busy, o_done
    );
endinterface

// File: rtl/shift_reg_arbiter.sv
// Two requesters share one shift register under round-robin arbitration; the winner's word
// is loaded in IDLE, shifted out LSB first over WIDTH cycles, then a one-cycle DONE follows.
module shift_reg_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    shift_reg_arbiter_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             last_q, last_d;
    logic             pick1;

    // last_q high means requester 1 won most recently, so requester 0 wins the next tie
    assign pick1 = bus.i_req1 & (~bus.i_req0 | ~last_q);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.i_req0 || bus.i_req1) begin
                    data_d  = pick1 ? bus.i_data1 : bus.i_data0;
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                    last_d  = pick1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                data_d = data_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            last_q  <= last_d;
        end
    end

    // All WIDTH shifts fill with zero, so the register is already empty in DONE and IDLE
    assign bus.o_gnt0        = gnt0_q;
    assign bus.o_gnt1        = gnt1_q;
    assign bus.o_storedValue = data_q;
    assign bus.o_serial      = (state_q == SHIFT) & data_q[0];
    assign bus.o_busy        = (state_q != IDLE);
    assign bus.o_done        = (state_q == DONE);
endmodule

// File: tb/tb_shift_reg_arbiter.sv
// Scenario tasks for shift_reg_arbiter, checked every cycle against a transaction-level model
// that tracks only "which word was loaded and how many cycles ago".
module tb_shift_reg_arbiter;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shift_reg_arbiter_if #(.WIDTH(WIDTH)) bus ();

    shift_reg_arbiter #(.WIDTH(WIDTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: mPhase -1 = idle, 0..7 = cycles since load, 8 = done cycle
    int         mPhase  = -1;
    int         mLast   = 1;
    int         mWinner = -1;
    logic [7:0] mVal    = 8'h00;

    // {gnt0, gnt1, busy, done, serial, storedValue}
    logic [12:0] obsVec;
    assign obsVec = {bus.o_gnt0, bus.o_gnt1, bus.o_busy, bus.o_done, bus.o_serial, bus.o_storedValue};

    function automatic logic [12:0] expOut();
        logic [12:0] e;
        e = '0;
        if (mPhase >= 0) e[10] = 1'b1;
        if (mPhase == 8) e[9] = 1'b1;
        if (mPhase >= 0 && mPhase <= 7) begin
            e[7:0] = 8'(mVal >> mPhase);
            e[8]   = e[0];
        end
        if (mPhase == 0) begin
            e[12] = (mWinner == 0);
            e[11] = (mWinner == 1);
        end
        return e;
    endfunction

    task automatic modelStep();
        if (!rst) begin
            mPhase  = -1;
            mLast   = 1;
            mWinner = -1;
        end else if (mPhase < 0) begin
            if (bus.i_req0 || bus.i_req1) begin
                if (bus.i_req0 && bus.i_req1) mWinner = 1 - mLast;
                else                          mWinner = bus.i_req0 ? 0 : 1;
                mVal   = (mWinner == 0) ? bus.i_data0 : bus.i_data1;
                mLast  = mWinner;
                mPhase = 0;
            end
        end else if (mPhase == 8) begin
            mPhase = -1;
        end else begin
            mPhase++;
        end
    endtask

    // Inputs only change 1 time unit after an edge, so the model sees what the DUT sampled
    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic pulseReset();
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.i_req0  = 1'b1;
        bus.i_req1  = 1'b1;
        bus.i_data0 = 8'(($urandom));
        bus.i_data1 = 8'(($urandom));
        tick();
        tick();
        checks++;
        if (obsVec !== 13'h0000) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h expected %h", obsVec, 13'h0000);
        end
        checks++;
        if (obsVec !== expOut()) begin
            failures++;
            $display("[TB] FAIL reset_model: got %h expected %h", obsVec, expOut());
        end
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (obsVec !== 13'h0000) begin
            failures++;
            $display("[TB] FAIL reset_idle: got %h expected %h", obsVec, 13'h0000);
        end
    endtask

    task automatic test_single_load();
        logic [7:0] ser;
        int busyCnt, gntCnt, gntAt, doneCnt, doneAt;
        ser = '0; busyCnt = 0; gntCnt = 0; gntAt = -1; doneCnt = 0; doneAt = -1;
        pulseReset();
        bus.i_req0  = 1'b1;
        bus.i_data0 = 8'hA5;
        tick();
        bus.i_req0 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (obsVec !== expOut()) begin
                failures++;
                $display("[TB] FAIL single_load cycle %0d: got %h expected %h", c, obsVec, expOut());
            end
            if (c < 8) ser[c] = bus.o_serial;
            if (bus.o_busy) busyCnt++;
            if (bus.o_gnt0) begin gntCnt++; gntAt = c; end
            if (bus.o_done) begin doneCnt++; doneAt = c; end
            tick();
        end
        checks++;
        if (ser !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL single_serial: got %h expected %h", ser, 8'hA5);
        end
        checks++;
        if (busyCnt != 9) begin
            failures++;
            $display("[TB] FAIL single_busy_len: got %0d expected %0d", busyCnt, 9);
        end
        checks++;
        if (gntCnt != 1 || gntAt != 0) begin
            failures++;
            $display("[TB] FAIL single_gnt: got count %0d at %0d expected count 1 at 0", gntCnt, gntAt);
        end
        checks++;
        if (doneCnt != 1 || doneAt != 8) begin
            failures++;
            $display("[TB] FAIL single_done: got count %0d at %0d expected count 1 at 8", doneCnt, doneAt);
        end
    endtask

    task automatic test_contention();
        int order[$];
        int at[$];
        pulseReset();
        bus.i_req0  = 1'b1;
        bus.i_req1  = 1'b1;
        bus.i_data0 = 8'h1E;
        bus.i_data1 = 8'hD2;
        for (int c = 0; c < 40; c++) begin
            tick();
            checks++;
            if (obsVec !== expOut()) begin
                failures++;
                $display("[TB] FAIL contention cycle %0d: got %h expected %h", c, obsVec, expOut());
            end
            if (bus.o_gnt0 && bus.o_gnt1) begin
                failures++;
                $display("[TB] FAIL contention_both_gnt cycle %0d: got 11 expected at most one", c);
            end
            if (bus.o_gnt0) begin order.push_back(0); at.push_back(c); end
            if (bus.o_gnt1) begin order.push_back(1); at.push_back(c); end
        end
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
        checks++;
        if (order.size() != 4) begin
            failures++;
            $display("[TB] FAIL contention_count: got %0d expected %0d", order.size(), 4);
        end
        for (int i = 0; i < order.size() && i < 4; i++) begin
            checks++;
            if (order[i] != (i % 2) || (at[i] - at[0]) != 10 * i) begin
                failures++;
                $display("[TB] FAIL contention_order %0d: got req%0d after %0d expected req%0d after %0d",
                         i, order[i], at[i] - at[0], i % 2, 10 * i);
            end
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        logic [7:0] ser;
        int gnt1Cnt;
        ser = '0; gnt1Cnt = 0;
        pulseReset();
        bus.i_req0  = 1'b1;
        bus.i_data0 = 8'h5A;
        bus.i_data1 = 8'hFF;
        tick();
        bus.i_req0 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (obsVec !== expOut()) begin
                failures++;
                $display("[TB] FAIL busy_ignore cycle %0d: got %h expected %h", c, obsVec, expOut());
            end
            if (bus.o_gnt1) gnt1Cnt++;
            if (c < 8) ser[c] = bus.o_serial;
            if (c == 2) bus.i_req1 = 1'b1;
            if (c == 5) bus.i_req1 = 1'b0;
            tick();
        end
        checks++;
        if (gnt1Cnt != 0) begin
            failures++;
            $display("[TB] FAIL busy_ignore_gnt1: got %0d expected %0d", gnt1Cnt, 0);
        end
        checks++;
        if (ser !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL busy_ignore_serial: got %h expected %h", ser, 8'h5A);
        end
    endtask

    task automatic test_data_hold();
        logic [7:0] ser;
        ser = '0;
        pulseReset();
        bus.i_req0  = 1'b1;
        bus.i_data0 = 8'h3C;
        tick();
        bus.i_req0 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (obsVec !== expOut()) begin
                failures++;
                $display("[TB] FAIL data_hold cycle %0d: got %h expected %h", c, obsVec, expOut());
            end
            if (c < 8) ser[c] = bus.o_serial;
            if (c == 0) bus.i_data0 = 8'hFF;
            tick();
        end
        checks++;
        if (ser !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL data_hold_serial: got %h expected %h", ser, 8'h3C);
        end
    endtask

    task automatic test_reset_abort();
        pulseReset();
        bus.i_req0  = 1'b1;
        bus.i_data0 = 8'hFF;
        tick();
        bus.i_req0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (obsVec !== expOut()) begin
                failures++;
                $display("[TB] FAIL reset_abort cycle %0d: got %h expected %h", c, obsVec, expOut());
            end
            if (c < 4) tick();
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obsVec !== 13'h0000) begin
            failures++;
            $display("[TB] FAIL reset_abort_clear: got %h expected %h", obsVec, 13'h0000);
        end
        rst = 1'b1;
        bus.i_req0  = 1'b1;
        bus.i_req1  = 1'b1;
        bus.i_data0 = 8'h96;
        bus.i_data1 = 8'h69;
        tick();
        checks++;
        if ({bus.o_gnt0, bus.o_gnt1} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_abort_first_gnt: got %b expected %b", {bus.o_gnt0, bus.o_gnt1}, 2'b10);
        end
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (obsVec !== expOut()) begin
                failures++;
                $display("[TB] FAIL reset_abort_after cycle %0d: got %h expected %h", c, obsVec, expOut());
            end
            tick();
        end
    endtask

    task automatic test_shift_contents();
        logic [7:0] seq [9];
        seq = '{8'h81, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
        pulseReset();
        bus.i_req1  = 1'b1;
        bus.i_data1 = 8'h81;
        tick();
        bus.i_req1 = 1'b0;
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (bus.o_storedValue !== seq[c] || obsVec !== expOut()) begin
                failures++;
                $display("[TB] FAIL shift_contents cycle %0d: got %h/%h expected %h/%h",
                         c, bus.o_storedValue, obsVec, seq[c], expOut());
            end
            tick();
        end
    endtask

    task automatic test_random();
        pulseReset();
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 63) != 0);
            bus.i_req0  = 1'($urandom_range(0, 1));
            bus.i_req1  = 1'($urandom_range(0, 1));
            bus.i_data0 = 8'(($urandom));
            bus.i_data1 = 8'(($urandom));
            tick();
            checks++;
            if (obsVec !== expOut() || (bus.o_gnt0 && bus.o_gnt1)) begin
                failures++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", n, obsVec, expOut());
            end
        end
        rst = 1'b1;
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            checks++;
            if (obsVec !== expOut()) begin
                failures++;
                $display("[TB] FAIL random_drain cycle %0d: got %h expected %h", n, obsVec, expOut());
            end
        end
    endtask

    initial begin
        bus.i_req0  = 1'b0;
        bus.i_req1  = 1'b0;
        bus.i_data0 = '0;
        bus.i_data1 = '0;
        test_reset();
        test_single_load();
        test_contention();
        test_busy_ignore();
        test_data_hold();
        test_reset_abort();
        test_shift_contents();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
